// File: rtl/serial_nbit_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_nbit_subtractor
// Description : Bit-serial N-bit subtractor computing a - b - b_in, LSB first,
//               one bit per clock, with a start/busy/done handshake. The
//               difference and borrow-out are held in output registers until
//               the next completed operation.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_nbit_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic [N-1:0] diff,
    output logic         b_out,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] C_LAST_BIT = CW'(N - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_d_sh;
    logic          r_borrow;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_diff;
    logic          r_b_out;

    logic          w_x;
    logic          w_y;
    logic          w_d;
    logic          w_borrow_nxt;
    logic          w_last;

    // Full-subtractor cell operating on the current LSBs of the operand shifters
    assign w_x          = r_a_sh[0];
    assign w_y          = r_b_sh[0];
    assign w_d          = w_x ^ w_y ^ r_borrow;
    assign w_borrow_nxt = (~w_x & w_y) | (~w_x & r_borrow) | (w_y & r_borrow);
    assign w_last       = (r_cnt == C_LAST_BIT);

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is only honoured in IDLE, DONE always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state only
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, serial shifting and result commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_d_sh   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_b_out  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= b_in;
                        r_cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a_sh   <= {1'b0, r_a_sh[N-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[N-1:1]};
                    r_d_sh   <= {w_d, r_d_sh[N-1:1]};
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + C_CNT_ONE;
                    // The final bit completes the word: commit it in the same edge
                    if (w_last) begin
                        r_diff  <= {w_d, r_d_sh[N-1:1]};
                        r_b_out <= w_borrow_nxt;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign diff  = r_diff;
    assign b_out = r_b_out;

endmodule
`default_nettype wire
